// File: rtl/frame_buffer_pool.sv
`default_nettype none
// ============================================================================
//  Module   : frame_buffer_pool
//  Purpose  : Owns NUM_FRAMES frame buffers in pSRAM. Hands them to a single
//             producer (frame uploader) and a single consumer (frame
//             downloader). The consumer always gets the newest committed
//             frame. Each grant returns a base address and an index, and a
//             read grant also returns the frame sequence number. The block
//             counts READY frames that a newer commit overwrote.
//  Ports    : clk, reset (async, active-high)
//             producer : wr_acq_req -> wr_acq_ack, wr_base_addr, wr_buf_idx;
//                        wr_commit, wr_abort
//             consumer : rd_acq_req -> rd_acq_ack, rd_base_addr, rd_buf_idx,
//                        rd_frame_seq; rd_release
//             status   : drop_count (saturating), error (1-cycle pulse)
//  Revision : 1.0  initial release
// ============================================================================
module frame_buffer_pool #(
    parameter int NUM_FRAMES   = 3,
    parameter int ADDR_WIDTH   = 21,
    parameter int BASE_ADDR    = 0,
    parameter int FRAME_STRIDE = 307232,
    parameter int SEQ_WIDTH    = 8,
    parameter int DROP_WIDTH   = 16,
    localparam int IDX_W       = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_acq_req,
    output logic                  wr_acq_ack,
    output logic [ADDR_WIDTH-1:0] wr_base_addr,
    output logic [IDX_W-1:0]      wr_buf_idx,
    input  logic                  wr_commit,
    input  logic                  wr_abort,
    input  logic                  rd_acq_req,
    output logic                  rd_acq_ack,
    output logic [ADDR_WIDTH-1:0] rd_base_addr,
    output logic [IDX_W-1:0]      rd_buf_idx,
    output logic [SEQ_WIDTH-1:0]  rd_frame_seq,
    input  logic                  rd_release,
    output logic [DROP_WIDTH-1:0] drop_count,
    output logic                  error
);

    // Per-buffer ownership state
    localparam logic [1:0] c_buf_free    = 2'd0;
    localparam logic [1:0] c_buf_writing = 2'd1;
    localparam logic [1:0] c_buf_ready   = 2'd2;
    localparam logic [1:0] c_buf_reading = 2'd3;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_GRANT = 2'd1,
        WR_HOLD  = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_GRANT = 2'd1,
        RD_HOLD  = 2'd2
    } rd_state_t;

    // Base address of every buffer is an elaboration-time constant.
    logic [ADDR_WIDTH-1:0] w_base_lut [NUM_FRAMES];

    for (genvar gi = 0; gi < NUM_FRAMES; gi++) begin : g_base_lut
        localparam logic [63:0] c_base_full =
            64'(BASE_ADDR) + 64'(gi) * 64'(FRAME_STRIDE);
        assign w_base_lut[gi] = c_base_full[ADDR_WIDTH-1:0];
    end

    // Registered state
    logic [1:0]            r_buf_state [NUM_FRAMES];
    wr_state_t             r_wr_state;
    rd_state_t             r_rd_state;
    logic [IDX_W-1:0]      r_wr_idx;
    logic [IDX_W-1:0]      r_rd_idx;
    logic [ADDR_WIDTH-1:0] r_wr_base;
    logic [ADDR_WIDTH-1:0] r_rd_base;
    logic [SEQ_WIDTH-1:0]  r_rd_seq;
    logic [SEQ_WIDTH-1:0]  r_seq_cnt;
    logic [SEQ_WIDTH-1:0]  r_ready_seq;
    logic [DROP_WIDTH-1:0] r_drop_cnt;
    logic                  r_error;

    // Next-state values
    logic [1:0]            w_buf_nxt [NUM_FRAMES];
    wr_state_t             w_wr_state_nxt;
    rd_state_t             w_rd_state_nxt;
    logic [IDX_W-1:0]      w_wr_idx_nxt;
    logic [IDX_W-1:0]      w_rd_idx_nxt;
    logic [ADDR_WIDTH-1:0] w_wr_base_nxt;
    logic [ADDR_WIDTH-1:0] w_rd_base_nxt;
    logic [SEQ_WIDTH-1:0]  w_rd_seq_nxt;
    logic [SEQ_WIDTH-1:0]  w_seq_cnt_nxt;
    logic [SEQ_WIDTH-1:0]  w_ready_seq_nxt;
    logic [DROP_WIDTH-1:0] w_drop_nxt;
    logic                  w_error_nxt;

    // Buffer scan results (taken from the registered buffer state only)
    logic                  w_free_found;
    logic [IDX_W-1:0]      w_free_idx;
    logic                  w_ready_found;
    logic [IDX_W-1:0]      w_ready_idx;
    logic                  w_rd_take;

    // Descending scan so the lowest matching index is the one kept.
    always_comb begin
        w_free_found  = 1'b0;
        w_free_idx    = '0;
        w_ready_found = 1'b0;
        w_ready_idx   = '0;
        for (int i = NUM_FRAMES - 1; i >= 0; i--) begin
            if (r_buf_state[i] == c_buf_free) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
            if (r_buf_state[i] == c_buf_ready) begin
                w_ready_found = 1'b1;
                w_ready_idx   = IDX_W'(i);
            end
        end
    end

    // The reader takes the READY buffer only when it is idle and a frame exists.
    assign w_rd_take = (r_rd_state == RD_IDLE) && rd_acq_req && w_ready_found;

    always_comb begin
        w_buf_nxt       = r_buf_state;
        w_wr_state_nxt  = r_wr_state;
        w_rd_state_nxt  = r_rd_state;
        w_wr_idx_nxt    = r_wr_idx;
        w_rd_idx_nxt    = r_rd_idx;
        w_wr_base_nxt   = r_wr_base;
        w_rd_base_nxt   = r_rd_base;
        w_rd_seq_nxt    = r_rd_seq;
        w_seq_cnt_nxt   = r_seq_cnt;
        w_ready_seq_nxt = r_ready_seq;
        w_drop_nxt      = r_drop_cnt;
        w_error_nxt     = 1'b0;

        // ---------------- consumer side ----------------
        case (r_rd_state)
            RD_IDLE: begin
                if (w_rd_take) begin
                    w_buf_nxt[w_ready_idx] = c_buf_reading;
                    w_rd_idx_nxt           = w_ready_idx;
                    w_rd_base_nxt          = w_base_lut[w_ready_idx];
                    w_rd_seq_nxt           = r_ready_seq;
                    w_rd_state_nxt         = RD_GRANT;
                end
            end
            RD_GRANT: w_rd_state_nxt = RD_HOLD;
            RD_HOLD: begin
                if (rd_release) begin
                    w_buf_nxt[r_rd_idx] = c_buf_free;
                    w_rd_state_nxt      = RD_IDLE;
                end
            end
            default: w_rd_state_nxt = RD_IDLE;
        endcase

        if (rd_release && (r_rd_state != RD_HOLD)) begin
            w_error_nxt = 1'b1;
        end

        // ---------------- producer side ----------------
        case (r_wr_state)
            WR_IDLE: begin
                if (wr_acq_req) begin
                    if (w_free_found) begin
                        w_buf_nxt[w_free_idx] = c_buf_writing;
                        w_wr_idx_nxt          = w_free_idx;
                        w_wr_base_nxt         = w_base_lut[w_free_idx];
                        w_wr_state_nxt        = WR_GRANT;
                    end else begin
                        w_error_nxt = 1'b1;
                    end
                end
            end
            WR_GRANT: w_wr_state_nxt = WR_HOLD;
            WR_HOLD: begin
                if (wr_commit) begin
                    // A READY frame that the reader grabs on this same edge
                    // is now READING; it is not overwritten and not counted.
                    if (w_ready_found && !w_rd_take) begin
                        w_buf_nxt[w_ready_idx] = c_buf_free;
                        if (r_drop_cnt != {DROP_WIDTH{1'b1}}) begin
                            w_drop_nxt = r_drop_cnt + 1'b1;
                        end
                    end
                    w_buf_nxt[r_wr_idx] = c_buf_ready;
                    w_ready_seq_nxt     = r_seq_cnt;
                    w_seq_cnt_nxt       = r_seq_cnt + 1'b1;
                    w_wr_state_nxt      = WR_IDLE;
                    if (wr_abort) begin
                        w_error_nxt = 1'b1;
                    end
                end else if (wr_abort) begin
                    w_buf_nxt[r_wr_idx] = c_buf_free;
                    w_wr_state_nxt      = WR_IDLE;
                end
            end
            default: w_wr_state_nxt = WR_IDLE;
        endcase

        if ((wr_commit || wr_abort) && (r_wr_state != WR_HOLD)) begin
            w_error_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_FRAMES; i++) begin
                r_buf_state[i] <= c_buf_free;
            end
            r_wr_state  <= WR_IDLE;
            r_rd_state  <= RD_IDLE;
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_wr_base   <= '0;
            r_rd_base   <= '0;
            r_rd_seq    <= '0;
            r_seq_cnt   <= '0;
            r_ready_seq <= '0;
            r_drop_cnt  <= '0;
            r_error     <= 1'b0;
        end else begin
            r_buf_state <= w_buf_nxt;
            r_wr_state  <= w_wr_state_nxt;
            r_rd_state  <= w_rd_state_nxt;
            r_wr_idx    <= w_wr_idx_nxt;
            r_rd_idx    <= w_rd_idx_nxt;
            r_wr_base   <= w_wr_base_nxt;
            r_rd_base   <= w_rd_base_nxt;
            r_rd_seq    <= w_rd_seq_nxt;
            r_seq_cnt   <= w_seq_cnt_nxt;
            r_ready_seq <= w_ready_seq_nxt;
            r_drop_cnt  <= w_drop_nxt;
            r_error     <= w_error_nxt;
        end
    end

    assign wr_acq_ack   = (r_wr_state == WR_GRANT);
    assign wr_base_addr = r_wr_base;
    assign wr_buf_idx   = r_wr_idx;
    assign rd_acq_ack   = (r_rd_state == RD_GRANT);
    assign rd_base_addr = r_rd_base;
    assign rd_buf_idx   = r_rd_idx;
    assign rd_frame_seq = r_rd_seq;
    assign drop_count   = r_drop_cnt;
    assign error        = r_error;

endmodule
`default_nettype wire
